traffic_phase_scheduler: RTL and testbench

TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

---
 rtl/traffic_phase_scheduler.sv | 123 ++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// Two-approach traffic light phase scheduler with pedestrian walk phase.
// Sensor-driven green extension, yellow and all-red clearance, Moore lamps.
module traffic_phase_scheduler #(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 12,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 6,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensorA,
    input  logic       sensorB,
    input  logic       ped_req,
    output logic       redLightA,
    output logic       yellowLightA,
    output logic       greenLightA,
    output logic       redLightB,
    output logic       yellowLightB,
    output logic       greenLightB,
    output logic       walk,
    output logic       ped_wait,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        GREEN_A  = 3'd0,
        YELLOW_A = 3'd1,
        ALLRED_A = 3'd2,
        GREEN_B  = 3'd3,
        YELLOW_B = 3'd4,
        ALLRED_B = 3'd5,
        WALK     = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] T_MIN = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] T_MAX = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] T_YEL = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] T_ALR = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] T_WLK = CNT_W'(WALK_T - 1);

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] timer;
    logic             last_b;
    logic [6:0]       lamps;
    logic             is_green;

    // Lamp pattern {rA,yA,gA,rB,yB,gB,walk}; the idle approach always shows red.
    function automatic logic [6:0] lamps_of(state_t s);
        case (s)
            GREEN_A:  lamps_of = 7'b001_100_0;
            YELLOW_A: lamps_of = 7'b010_100_0;
            ALLRED_A: lamps_of = 7'b100_100_0;
            GREEN_B:  lamps_of = 7'b100_001_0;
            YELLOW_B: lamps_of = 7'b100_010_0;
            ALLRED_B: lamps_of = 7'b100_100_0;
            WALK:     lamps_of = 7'b100_100_1;
            default:  lamps_of = 7'b001_100_0;
        endcase
    endfunction

    assign is_green = (state == GREEN_A) || (state == GREEN_B);

    // Next-state rules: green holds until demand elsewhere, capped under contention.
    always_comb begin
        nxt = state;
        case (state)
            GREEN_A:
                if (timer >= T_MIN && (sensorB || ped_wait) &&
                    (!sensorA || timer == T_MAX))
                    nxt = YELLOW_A;
            YELLOW_A:
                if (timer == T_YEL) nxt = ALLRED_A;
            ALLRED_A:
                if (timer == T_ALR) nxt = ped_wait ? WALK : GREEN_B;
            GREEN_B:
                if (timer >= T_MIN && (sensorA || ped_wait) &&
                    (!sensorB || timer == T_MAX))
                    nxt = YELLOW_B;
            YELLOW_B:
                if (timer == T_YEL) nxt = ALLRED_B;
            ALLRED_B:
                if (timer == T_ALR) nxt = ped_wait ? WALK : GREEN_A;
            WALK:
                if (timer == T_WLK) nxt = last_b ? GREEN_A : GREEN_B;
            default:
                nxt = GREEN_A;
        endcase
    end

    // State, dwell timer, pedestrian latch, last-served memory and lamp registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= GREEN_A;
            timer    <= '0;
            ped_wait <= 1'b0;
            last_b   <= 1'b0;
            lamps    <= lamps_of(GREEN_A);
        end else begin
            state <= nxt;
            lamps <= lamps_of(nxt);
            if (nxt != state)
                timer <= '0;
            else if (!(is_green && timer == T_MAX))
                timer <= timer + CNT_W'(1);
            if (state == GREEN_A)
                last_b <= 1'b0;
            else if (state == GREEN_B)
                last_b <= 1'b1;
            if (nxt == WALK && state != WALK)
                ped_wait <= 1'b0;
            else if (ped_req && state != WALK)
                ped_wait <= 1'b1;
        end
    end

    assign {redLightA, yellowLightA, greenLightA,
            redLightB, yellowLightB, greenLightB, walk} = lamps;
    assign phase = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed and randomized checks of traffic_phase_scheduler against
// a phase/dwell reference model and lamp-safety invariants.
module tb_traffic_phase_scheduler;

    localparam int MIN_GREEN = 4;
    localparam int MAX_GREEN = 12;
    localparam int YELLOW_T  = 3;
    localparam int ALLRED_T  = 1;
    localparam int WALK_T    = 6;

    logic       clk;
    logic       rst;
    logic       sensorA, sensorB, ped_req;
    logic       redLightA, yellowLightA, greenLightA;
    logic       redLightB, yellowLightB, greenLightB;
    logic       walk, ped_wait;
    logic [2:0] phase;

    traffic_phase_scheduler dut (
        .clk(clk), .rst(rst),
        .sensorA(sensorA), .sensorB(sensorB), .ped_req(ped_req),
        .redLightA(redLightA), .yellowLightA(yellowLightA),
        .greenLightA(greenLightA), .redLightB(redLightB),
        .yellowLightB(yellowLightB), .greenLightB(greenLightB),
        .walk(walk), .ped_wait(ped_wait), .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] lamp_tab [0:6];

    int m_ph, m_dw, n_ph, n_dw;
    bit m_pw, m_lb, n_pw, n_lb;

    int prev_g;
    bit seen_y, seen_ar, valid;

    int rec[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] lamps_obs();
        return {redLightA, yellowLightA, greenLightA,
                redLightB, yellowLightB, greenLightB, walk};
    endfunction

    function automatic int run_len(int start);
        int n = 0;
        if (start >= rec.size()) return 0;
        for (int i = start; i < rec.size() && rec[i] == rec[start]; i++)
            n++;
        return n;
    endfunction

    task automatic model_calc(input bit a, input bit b, input bit p);
        bit own, oth;
        n_ph = m_ph;
        own  = (m_ph == 0) ? a : b;
        oth  = (m_ph == 0) ? b : a;
        case (m_ph)
            0, 3:
                if (m_dw + 1 >= MIN_GREEN && (oth || m_pw) &&
                    (!own || m_dw + 1 >= MAX_GREEN))
                    n_ph = m_ph + 1;
            1, 4:
                if (m_dw + 1 == YELLOW_T) n_ph = m_ph + 1;
            2:
                if (m_dw + 1 == ALLRED_T) n_ph = m_pw ? 6 : 3;
            5:
                if (m_dw + 1 == ALLRED_T) n_ph = m_pw ? 6 : 0;
            6:
                if (m_dw + 1 == WALK_T) n_ph = m_lb ? 0 : 3;
            default:
                n_ph = 0;
        endcase
        n_dw = (n_ph != m_ph) ? 0 : m_dw + 1;
        if (n_ph == 6 && m_ph != 6) n_pw = 1'b0;
        else if (p && m_ph != 6)    n_pw = 1'b1;
        else                        n_pw = m_pw;
        n_lb = (m_ph == 0) ? 1'b0 : (m_ph == 3) ? 1'b1 : m_lb;
    endtask

    task automatic observe();
        int g;
        check("phase", 32'(phase), 32'(m_ph));
        check("lamps", 32'(lamps_obs()), 32'(lamp_tab[m_ph]));
        check("ped_wait", 32'(ped_wait), 32'(m_pw));
        check("excl", {30'd0, greenLightA & greenLightB,
                       (greenLightA | greenLightB) & walk}, 32'd0);
        g = greenLightA ? 1 : (greenLightB ? 2 : 0);
        if (g != 0 && g != prev_g && valid)
            check("transit", {30'd0, seen_y, seen_ar}, 32'd3);
        if (g != 0) begin
            valid   = 1'b1;
            seen_y  = 1'b0;
            seen_ar = 1'b0;
        end
        if (yellowLightA | yellowLightB) seen_y = 1'b1;
        if (redLightA & redLightB & !walk) seen_ar = 1'b1;
        prev_g = g;
        rec.push_back(int'(phase));
    endtask

    task automatic step(input bit a, input bit b, input bit p);
        sensorA = a;
        sensorB = b;
        ped_req = p;
        model_calc(a, b, p);
        @(posedge clk);
        #1;
        m_ph = n_ph;
        m_dw = n_dw;
        m_pw = n_pw;
        m_lb = n_lb;
        observe();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_lamps", 32'(lamps_obs()), 32'(7'b001_100_0));
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_pw", 32'(ped_wait), 32'd0);
        sensorA = 1'b0;
        sensorB = 1'b0;
        ped_req = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
        m_ph    = 0;
        m_dw    = 0;
        m_pw    = 1'b0;
        m_lb    = 1'b0;
        prev_g  = 1;
        valid   = 1'b1;
        seen_y  = 1'b0;
        seen_ar = 1'b0;
        rec.delete();
        rec.push_back(int'(phase));
    endtask

    initial begin
        lamp_tab[0] = 7'b001_100_0;
        lamp_tab[1] = 7'b010_100_0;
        lamp_tab[2] = 7'b100_100_0;
        lamp_tab[3] = 7'b100_001_0;
        lamp_tab[4] = 7'b100_010_0;
        lamp_tab[5] = 7'b100_100_0;
        lamp_tab[6] = 7'b100_100_1;
        rst     = 1'b0;
        sensorA = 1'b0;
        sensorB = 1'b0;
        ped_req = 1'b0;
        #1;

        do_reset();
        for (int i = 0; i < 9; i++) step(0, 1, 0);
        check("r30_ga_len", 32'(run_len(0)), 32'd4);
        check("r30_ya", 32'(rec[4]), 32'd1);
        check("r30_ya_len", 32'(run_len(4)), 32'd3);
        check("r30_ar", 32'(rec[7]), 32'd2);
        check("r30_ar_len", 32'(run_len(7)), 32'd1);
        check("r30_gb", 32'(rec[8]), 32'd3);

        do_reset();
        for (int i = 0; i < 30; i++) step(1, 1, 0);
        check("r31_ga_len", 32'(run_len(0)), 32'd12);
        check("r31_ya", 32'(rec[12]), 32'd1);
        check("r31_ya_len", 32'(run_len(12)), 32'd3);
        check("r31_ar", 32'(rec[15]), 32'd2);
        check("r31_gb", 32'(rec[16]), 32'd3);
        check("r31_gb_len", 32'(run_len(16)), 32'd12);
        check("r31_yb", 32'(rec[28]), 32'd4);

        do_reset();
        for (int i = 0; i < 50; i++) step(0, 0, 0);
        check("r32_idle_len", 32'(run_len(0)), 32'd51);

        do_reset();
        step(0, 0, 0);
        step(0, 0, 1);
        check("r33_pw_set", 32'(ped_wait), 32'd1);
        for (int i = 0; i < 12; i++) step(0, 0, 0);
        check("r33_ga_len", 32'(run_len(0)), 32'd4);
        check("r33_ya", 32'(rec[4]), 32'd1);
        check("r33_ya_len", 32'(run_len(4)), 32'd3);
        check("r33_ar", 32'(rec[7]), 32'd2);
        check("r33_walk", 32'(rec[8]), 32'd6);
        check("r33_walk_len", 32'(run_len(8)), 32'd6);
        check("r33_gb", 32'(rec[14]), 32'd3);
        check("r33_pw_clr", 32'(ped_wait), 32'd0);

        do_reset();
        for (int i = 0; i < 8; i++) step(0, 1, 0);
        step(1, 0, 1);
        for (int i = 0; i < 20 && phase != 3'd4; i++) step(1, 0, 0);
        check("r34_in_yb", 32'(phase), 32'd4);
        check("r34_pw", 32'(ped_wait), 32'd1);
        #2;
        do_reset();

        begin
            bit a, b;
            a = 1'b0;
            b = 1'b0;
            for (int i = 0; i < 10000; i++) begin
                if ($urandom_range(0, 7) == 0) a = ~a;
                if ($urandom_range(0, 7) == 0) b = ~b;
                step(a, b, $urandom_range(0, 19) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
